// File: rtl/key_debounce_bank_if.sv
// Key bank signal bundle: raw active-low KEY pins in, debounced
// level and press/release pulses out.
interface key_debounce_bank_if #(
   parameter int NUM_KEYS = 4
);
   logic [NUM_KEYS-1:0] KEY;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;

   modport master (
      output KEY,
      input  key_level,
      input  key_press,
      input  key_release
   );

   modport slave (
      input  KEY,
      output key_level,
      output key_press,
      output key_release
   );
endinterface

// File: rtl/key_debounce_bank.sv
// Multi-channel key synchroniser, debouncer and edge-pulse generator.
// Optional auto-repeat of key_press while held: define KEY_REPEAT_EN.
module key_debounce_bank #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input logic           clk,
   input logic           rst_n,
   key_debounce_bank_if.slave kb
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_PEND,
      PRESSED,
      REL_PEND
   } st_t;

   if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("key_debounce_bank: illegal parameter set");
   end

`ifdef KEY_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RMAX + 1);
   localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);
`endif

   logic [NUM_KEYS-1:0] level_v;
   logic [NUM_KEYS-1:0] press_v;
   logic [NUM_KEYS-1:0] release_v;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      st_t                    state_q, state_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   press_q, press_d;
      logic                   release_q, release_d;
`ifdef KEY_REPEAT_EN
      logic [RW-1:0]          rep_q, rep_d;
      logic                   first_q, first_d;
      logic                   rep_fire;
`endif

      // Idle-high pins: reset the chain to "released".
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sync_q <= '1;
         else        sync_q <= {sync_q[SYNC_STAGES-2:0], kb.KEY[g]};
      end

      assign s = ~sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q     <= '0;
            first_q   <= 1'b1;
`endif
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef KEY_REPEAT_EN
            rep_q     <= rep_d;
            first_q   <= first_d;
`endif
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         unique case (state_q)
            IDLE: begin
               if (s) begin
                  state_d = PRESS_PEND;
                  cnt_d   = CW'(1);
               end
            end
            PRESS_PEND: begin
               if (!s) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            PRESSED: begin
               if (!s) begin
                  state_d = REL_PEND;
                  cnt_d   = CW'(1);
               end
            end
            REL_PEND: begin
               if (s) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

`ifdef KEY_REPEAT_EN
      // Repeat timer only runs across PRESSED->PRESSED cycles.
      always_comb begin
         rep_d    = '0;
         first_d  = 1'b1;
         rep_fire = 1'b0;
         if (state_q == PRESSED && state_d == PRESSED) begin
            first_d = first_q;
            if (rep_q == (first_q ? REP_FIRST : REP_NEXT)) begin
               rep_fire = 1'b1;
               first_d  = 1'b0;
            end else begin
               rep_d = rep_q + RW'(1);
            end
         end
      end
`endif

      always_comb begin
         level_d   = (state_d == PRESSED) || (state_d == REL_PEND);
         press_d   = (state_q == PRESS_PEND) && (state_d == PRESSED);
         release_d = (state_q == REL_PEND) && (state_d == IDLE);
`ifdef KEY_REPEAT_EN
         press_d   = press_d | rep_fire;
`endif
      end

      assign level_v[g]   = level_q;
      assign press_v[g]   = press_q;
      assign release_v[g] = release_q;
   end

   assign kb.key_level   = level_v;
   assign kb.key_press   = press_v;
   assign kb.key_release = release_v;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Bench for key_debounce_bank: expected pulses queued at stimulus time,
// compared each cycle against key_press/key_release.
module tb_key_debounce_bank;

   localparam int NK = 4;
   localparam int DB = 4;
   localparam int SS = 2;
   localparam int LAT = SS + DB;

   typedef struct {
      int cyc;
      bit rel;
      int ch;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;
   ev_t  sb[$];

   key_debounce_bank_if #(.NUM_KEYS(NK)) kb ();

   key_debounce_bank #(
      .NUM_KEYS(NK),
      .DEBOUNCE_CYCLES(DB),
      .SYNC_STAGES(SS),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .kb(kb)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pop all events due this cycle and compare whole pulse vectors.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         logic [NK-1:0] ep;
         logic [NK-1:0] er;
         ep = '0;
         er = '0;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               if (sb[i].rel) er[sb[i].ch] = 1'b1;
               else           ep[sb[i].ch] = 1'b1;
               sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
               total++;
               bad++;
               $display("FAIL stale_event cyc=%0d due=%0d ch=%0d", cyc, sb[i].cyc, sb[i].ch);
               sb.delete(i);
            end
         end
         total++;
         if (kb.key_press !== ep) begin
            bad++;
            $display("FAIL key_press cyc=%0d got=%b exp=%b", cyc, kb.key_press, ep);
         end
         total++;
         if (kb.key_release !== er) begin
            bad++;
            $display("FAIL key_release cyc=%0d got=%b exp=%b", cyc, kb.key_release, er);
         end
      end
   end

   task automatic push(input int c, input bit r, input int ch);
      ev_t e;
      e.cyc = c;
      e.rel = r;
      e.ch  = ch;
      sb.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      kb.KEY = 4'b0101;
      #1 rst_n = 1'b0;
      #2;
      total++;
      if ({kb.key_level, kb.key_press, kb.key_release} !== 12'h000) begin
         bad++;
         $display("FAIL reset_async got=%h exp=000",
                  {kb.key_level, kb.key_press, kb.key_release});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         kb.KEY = ~kb.KEY;
      end
      @(negedge clk);
      total++;
      if ({kb.key_level, kb.key_press, kb.key_release} !== 12'h000) begin
         bad++;
         $display("FAIL reset_hold got=%h exp=000",
                  {kb.key_level, kb.key_press, kb.key_release});
      end
      kb.KEY = 4'b1110;
      rst_n = 1'b1;
      mon_en = 1'b1;
      push(cyc + 1 + LAT, 1'b0, 0);
      cycles(LAT + 1);
      total++;
      if (kb.key_level !== 4'b0001) begin
         bad++;
         $display("FAIL reset_held_level got=%b exp=0001", kb.key_level);
      end
      kb.KEY = 4'b1111;
      push(cyc + 1 + LAT, 1'b1, 0);
      cycles(LAT + 2);
      total++;
      if (kb.key_level !== 4'b0000) begin
         bad++;
         $display("FAIL reset_release_level got=%b exp=0000", kb.key_level);
      end
   endtask

   task automatic test_clean_press;
      int k;
      kb.KEY[1] = 1'b0;
      k = cyc + 1;
      push(k + LAT, 1'b0, 1);
`ifdef KEY_REPEAT_EN
      push(k + LAT + 10, 1'b0, 1);
      push(k + LAT + 13, 1'b0, 1);
`endif
      cycles(LAT + 1);
      total++;
      if (kb.key_level !== 4'b0010) begin
         bad++;
         $display("FAIL press_level got=%b exp=0010", kb.key_level);
      end
      cycles(13);
      kb.KEY[1] = 1'b1;
      push(cyc + 1 + LAT, 1'b1, 1);
      cycles(LAT + 1);
      total++;
      if (kb.key_level !== 4'b0000) begin
         bad++;
         $display("FAIL release_level got=%b exp=0000", kb.key_level);
      end
      cycles(2);
   endtask

   task automatic test_bounce;
      int k;
      int seq[4] = '{3, 1, 3, 1};
      for (int i = 0; i < 4; i++) begin
         kb.KEY[2] = (i % 2 == 1);
         cycles(seq[i]);
      end
      cycles(4);
      total++;
      if (kb.key_level[2] !== 1'b0) begin
         bad++;
         $display("FAIL bounce_level got=%b exp=0", kb.key_level[2]);
      end
      kb.KEY[2] = 1'b0;
      k = cyc + 1;
      push(k + LAT, 1'b0, 2);
      cycles(10);
      total++;
      if (kb.key_level[2] !== 1'b1) begin
         bad++;
         $display("FAIL bounce_accept_level got=%b exp=1", kb.key_level[2]);
      end
      kb.KEY[2] = 1'b1;
      push(cyc + 1 + LAT, 1'b1, 2);
      cycles(LAT + 2);
   endtask

   task automatic test_simultaneous;
      int k;
      kb.KEY[3] = 1'b0;
      kb.KEY[0] = 1'b0;
      k = cyc + 1;
      push(k + LAT, 1'b0, 3);
      push(k + LAT, 1'b0, 0);
      cycles(LAT + 1);
      total++;
      if (kb.key_level !== 4'b1001) begin
         bad++;
         $display("FAIL simul_level got=%b exp=1001", kb.key_level);
      end
      kb.KEY[3] = 1'b1;
      push(cyc + 1 + LAT, 1'b1, 3);
      cycles(LAT + 1);
      total++;
      if (kb.key_level !== 4'b0001) begin
         bad++;
         $display("FAIL simul_indep got=%b exp=0001", kb.key_level);
      end
      kb.KEY[0] = 1'b1;
      push(cyc + 1 + LAT, 1'b1, 0);
      cycles(LAT + 2);
   endtask

   task automatic test_reset_mid;
      kb.KEY[1] = 1'b0;
      cycles(4);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({kb.key_level, kb.key_press, kb.key_release} !== 12'h000) begin
         bad++;
         $display("FAIL midrst_async got=%h exp=000",
                  {kb.key_level, kb.key_press, kb.key_release});
      end
      cycles(2);
      rst_n = 1'b1;
      push(cyc + 1 + LAT, 1'b0, 1);
      cycles(LAT + 1);
      total++;
      if (kb.key_level !== 4'b0010) begin
         bad++;
         $display("FAIL midrst_level got=%b exp=0010", kb.key_level);
      end
      kb.KEY[1] = 1'b1;
      push(cyc + 1 + LAT, 1'b1, 1);
      cycles(LAT + 2);
   endtask

   task automatic test_repeat;
      int acc;
      kb.KEY[0] = 1'b0;
      acc = cyc + 1 + LAT;
      push(acc, 1'b0, 0);
`ifdef KEY_REPEAT_EN
      for (int t = 10; t <= 28; t += 3) push(acc + t, 1'b0, 0);
`endif
      cycles(LAT + 1);
      cycles(28);
      total++;
      if (kb.key_level[0] !== 1'b1) begin
         bad++;
         $display("FAIL repeat_level got=%b exp=1", kb.key_level[0]);
      end
      kb.KEY[0] = 1'b1;
      push(cyc + 1 + LAT, 1'b1, 0);
      cycles(LAT + 4);
      total++;
      if (kb.key_level !== 4'b0000) begin
         bad++;
         $display("FAIL repeat_end_level got=%b exp=0000", kb.key_level);
      end
   endtask

   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_simultaneous;
      test_reset_mid;
      test_repeat;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL pending_events got=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
